// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - word RAM answering one-cycle read/write request pulses after LATENCY cycles
// Optional feature: define RAM_BOUNDS_CHECK_EN to fault out-of-range accesses instead of wrapping.
module ram_responder #(
   parameter int    DEPTH     = 1024,
   parameter int    ADDR_BITS = 10,
   parameter int    LATENCY   = 2,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ramAddress,
   input  logic [31:0] ramWriteData,
   input  logic        readReq,
   input  logic        writeReq,
   output logic [31:0] ramReadData,
   output logic        readAck,
   output logic        writeAck,
   output logic        busy,
   output logic        fault
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

   logic [31:0] mem [DEPTH];

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]   idx_q, idx_d;
   logic [31:0]            wdata_q, wdata_d;
   logic                   is_wr_q, is_wr_d;
   logic                   oor_q, oor_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   rack_q, rack_d;
   logic                   wack_q, wack_d;
   logic                   busy_q, busy_d;
   logic                   fault_q, fault_d;

   logic                   req;
   logic [ADDR_BITS-1:0]   in_idx;
   logic                   in_oor;
   logic                   unused_addr;
   logic                   enter_ack;
   logic [ADDR_BITS-1:0]   acc_idx;
   logic [31:0]            acc_data;
   logic                   acc_wr;
   logic                   acc_oor;
   logic                   mem_we;

   assign req    = readReq | writeReq;
   assign in_idx = ramAddress[ADDR_BITS+1:2];

`ifdef RAM_BOUNDS_CHECK_EN
   assign in_oor      = |ramAddress[31:ADDR_BITS+2];
   assign unused_addr = ^ramAddress[1:0];
`else
   assign in_oor      = 1'b0;
   assign unused_addr = ^{ramAddress[31:ADDR_BITS+2], ramAddress[1:0]};
`endif

   // With LATENCY=1 the access happens on the sampling edge, so use the live inputs.
   always_comb begin
      enter_ack = ((state_q == S_IDLE) && req && (LATENCY == 1)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd0));
      if (state_q == S_IDLE) begin
         acc_idx  = in_idx;
         acc_data = ramWriteData;
         acc_wr   = writeReq;
         acc_oor  = in_oor;
      end else begin
         acc_idx  = idx_q;
         acc_data = wdata_q;
         acc_wr   = is_wr_q;
         acc_oor  = oor_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         is_wr_q <= 1'b0;
         oor_q   <= 1'b0;
         rdata_q <= 32'd0;
         rack_q  <= 1'b0;
         wack_q  <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         oor_q   <= oor_d;
         rdata_q <= rdata_d;
         rack_q  <= rack_d;
         wack_q  <= wack_d;
         busy_q  <= busy_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      oor_d   = oor_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               idx_d   = in_idx;
               wdata_d = ramWriteData;
               is_wr_d = writeReq;
               oor_d   = in_oor;
               if (LATENCY == 1) begin
                  state_d = S_ACK;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_ACK;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d  = (state_d != S_IDLE);
      rack_d  = enter_ack && !acc_wr;
      wack_d  = enter_ack && acc_wr;
      fault_d = enter_ack && acc_oor;
      mem_we  = wack_d && !acc_oor;
      rdata_d = rdata_q;
      if (rack_d) rdata_d = acc_oor ? 32'hdeadbeef : mem[acc_idx];
   end

   // Array has no reset: contents survive a controller reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[acc_idx] <= acc_data;
   end

   assign ramReadData = rdata_q;
   assign readAck     = rack_q;
   assign writeAck    = wack_q;
   assign busy        = busy_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - directed bench for ram_responder at LATENCY 1, 2 and 4
module tb_ram_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ram_address = 32'd0;
   logic [31:0] ram_write_data = 32'd0;
   logic        read_req = 1'b0;
   logic        write_req = 1'b0;

   logic [31:0] rdata [3];
   logic        rack  [3];
   logic        wack  [3];
   logic        busy  [3];
   logic        fault [3];

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ram_responder #(.LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset), .ramAddress(ram_address), .ramWriteData(ram_write_data),
      .readReq(read_req), .writeReq(write_req), .ramReadData(rdata[0]),
      .readAck(rack[0]), .writeAck(wack[0]), .busy(busy[0]), .fault(fault[0]));

   ram_responder #(.LATENCY(2)) dut_l2 (
      .clk(clk), .reset(reset), .ramAddress(ram_address), .ramWriteData(ram_write_data),
      .readReq(read_req), .writeReq(write_req), .ramReadData(rdata[1]),
      .readAck(rack[1]), .writeAck(wack[1]), .busy(busy[1]), .fault(fault[1]));

   ram_responder #(.LATENCY(4)) dut_l4 (
      .clk(clk), .reset(reset), .ramAddress(ram_address), .ramWriteData(ram_write_data),
      .readReq(read_req), .writeReq(write_req), .ramReadData(rdata[2]),
      .readAck(rack[2]), .writeAck(wack[2]), .busy(busy[2]), .fault(fault[2]));

   // Request present for one cycle; returns at the sample point of cycle 1 after the sampling edge.
   task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      read_req = rd; write_req = wr; ram_address = addr; ram_write_data = data;
      @(negedge clk);
      read_req = 1'b0; write_req = 1'b0;
   endtask

   task automatic observe(input int d, input int start, input int n,
                          output int first_rd, output int first_wr,
                          output int n_rd, output int n_wr, output bit flt);
      first_rd = -1; first_wr = -1; n_rd = 0; n_wr = 0; flt = 1'b0;
      for (int c = start; c < start + n; c++) begin
         if (c != start) @(negedge clk);
         if (rack[d] === 1'b1) begin n_rd++; if (first_rd < 0) first_rd = c; end
         if (wack[d] === 1'b1) begin n_wr++; if (first_wr < 0) first_wr = c; end
         if ((rack[d] === 1'b1 || wack[d] === 1'b1) && fault[d] === 1'b1) flt = 1'b1;
      end
   endtask

   task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
      int fr, fw, nr, nw; bit f;
      issue(1'b0, 1'b1, addr, data);
      observe(1, 1, 8, fr, fw, nr, nw, f);
   endtask

   task automatic read_word(input int d, input logic [31:0] addr, output logic [31:0] data,
                            output int lat, output bit flt);
      int fw, nr, nw;
      issue(1'b1, 1'b0, addr, 32'd0);
      observe(d, 1, 8, lat, fw, nr, nw, flt);
      data = rdata[d];
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_checks++; if (rdata[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rdata[d]); end
         n_checks++; if (rack[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rack[%0d]: got %b expected 0", d, rack[d]); end
         n_checks++; if (wack[d] !== 1'b0) begin n_fail++; $display("FAIL reset_wack[%0d]: got %b expected 0", d, wack[d]); end
         n_checks++; if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy[d]); end
         n_checks++; if (fault[d] !== 1'b0) begin n_fail++; $display("FAIL reset_fault[%0d]: got %b expected 0", d, fault[d]); end
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read;
      int fr, fw, nr, nw; bit f;
      issue(1'b0, 1'b1, 32'h10, 32'h12345678);
      observe(1, 1, 8, fr, fw, nr, nw, f);
      n_checks++; if (fw !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", fw); end
      n_checks++; if (nw !== 1) begin n_fail++; $display("FAIL wr_ack_cycles: got %0d expected 1", nw); end
      n_checks++; if (nr !== 0) begin n_fail++; $display("FAIL wr_spurious_rack: got %0d expected 0", nr); end
      issue(1'b1, 1'b0, 32'h10, 32'd0);
      observe(1, 1, 8, fr, fw, nr, nw, f);
      n_checks++; if (fr !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected 2", fr); end
      n_checks++; if (nr !== 1) begin n_fail++; $display("FAIL rd_ack_cycles: got %0d expected 1", nr); end
      n_checks++; if (rdata[1] !== 32'h12345678) begin n_fail++; $display("FAIL rd_data: got %h expected 12345678", rdata[1]); end
   endtask

   task automatic test_latency1;
      int fr, fw, nr, nw; bit f;
      issue(1'b0, 1'b1, 32'h0, 32'ha5a5a5a5);
      observe(0, 1, 8, fr, fw, nr, nw, f);
      n_checks++; if (fw !== 1) begin n_fail++; $display("FAIL l1_wr_latency: got %0d expected 1", fw); end
      issue(1'b1, 1'b0, 32'h0, 32'd0);
      n_checks++; if (rack[0] !== 1'b1) begin n_fail++; $display("FAIL l1_rack: got %b expected 1", rack[0]); end
      n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL l1_busy: got %b expected 1", busy[0]); end
      n_checks++; if (rdata[0] !== 32'ha5a5a5a5) begin n_fail++; $display("FAIL l1_data: got %h expected a5a5a5a5", rdata[0]); end
      @(negedge clk);
      n_checks++; if (rack[0] !== 1'b0) begin n_fail++; $display("FAIL l1_rack_clear: got %b expected 0", rack[0]); end
      n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL l1_busy_clear: got %b expected 0", busy[0]); end
      n_checks++; if (rdata[0] !== 32'ha5a5a5a5) begin n_fail++; $display("FAIL l1_data_held: got %h expected a5a5a5a5", rdata[0]); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_simultaneous;
      int fr, fw, nr, nw, lat; bit f; logic [31:0] data;
      issue(1'b1, 1'b1, 32'h8, 32'h55);
      observe(1, 1, 8, fr, fw, nr, nw, f);
      n_checks++; if (nw !== 1) begin n_fail++; $display("FAIL sim_wack: got %0d expected 1", nw); end
      n_checks++; if (nr !== 0) begin n_fail++; $display("FAIL sim_rack: got %0d expected 0", nr); end
      read_word(1, 32'h8, data, lat, f);
      n_checks++; if (data !== 32'h55) begin n_fail++; $display("FAIL sim_readback: got %h expected 00000055", data); end
   endtask

   task automatic test_drop_busy;
      int fr, fw, nr, nw, lat; bit f; logic [31:0] data;
      write_word(32'h40, 32'h4040);
      @(negedge clk);
      read_req = 1'b1; ram_address = 32'h40;
      @(negedge clk);
      read_req = 1'b0; write_req = 1'b1; ram_write_data = 32'hbad;
      @(negedge clk);
      write_req = 1'b0;
      observe(2, 2, 8, fr, fw, nr, nw, f);
      n_checks++; if (fr !== 4) begin n_fail++; $display("FAIL drop_rd_latency: got %0d expected 4", fr); end
      n_checks++; if (nr !== 1) begin n_fail++; $display("FAIL drop_rack_count: got %0d expected 1", nr); end
      n_checks++; if (nw !== 0) begin n_fail++; $display("FAIL drop_wack_count: got %0d expected 0", nw); end
      n_checks++; if (rdata[2] !== 32'h4040) begin n_fail++; $display("FAIL drop_rd_data: got %h expected 00004040", rdata[2]); end
      read_word(2, 32'h40, data, lat, f);
      n_checks++; if (data !== 32'h4040) begin n_fail++; $display("FAIL drop_word_kept: got %h expected 00004040", data); end
   endtask

   task automatic test_reset_mid_write;
      int fr, fw, nr, nw, lat; bit f; logic [31:0] data;
      write_word(32'h20, 32'h11);
      issue(1'b0, 1'b1, 32'h20, 32'h99);
      reset = 1'b1;
      #1;
      n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy[1]); end
      @(negedge clk);
      reset = 1'b0;
      observe(1, 1, 6, fr, fw, nr, nw, f);
      n_checks++; if (nw !== 0) begin n_fail++; $display("FAIL rst_mid_wack: got %0d expected 0", nw); end
      read_word(1, 32'h20, data, lat, f);
      n_checks++; if (data !== 32'h11) begin n_fail++; $display("FAIL rst_mid_word: got %h expected 00000011", data); end
   endtask

   task automatic test_bounds;
      int fr, fw, nr, nw, lat; bit f; logic [31:0] data;
      write_word(32'h4, 32'h04040404);
      issue(1'b0, 1'b1, 32'h1004, 32'hcafe);
      observe(1, 1, 8, fr, fw, nr, nw, f);
      n_checks++; if (nw !== 1) begin n_fail++; $display("FAIL oor_wack: got %0d expected 1", nw); end
`ifdef RAM_BOUNDS_CHECK_EN
      n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL oor_wr_fault: got %b expected 1", f); end
      read_word(1, 32'h1004, data, lat, f);
      n_checks++; if (data !== 32'hdeadbeef) begin n_fail++; $display("FAIL oor_rd_data: got %h expected deadbeef", data); end
      n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL oor_rd_fault: got %b expected 1", f); end
      read_word(1, 32'h4, data, lat, f);
      n_checks++; if (data !== 32'h04040404) begin n_fail++; $display("FAIL oor_word1_kept: got %h expected 04040404", data); end
`else
      n_checks++; if (f !== 1'b0) begin n_fail++; $display("FAIL alias_wr_fault: got %b expected 0", f); end
      read_word(1, 32'h4, data, lat, f);
      n_checks++; if (data !== 32'h0000cafe) begin n_fail++; $display("FAIL alias_word1: got %h expected 0000cafe", data); end
      n_checks++; if (f !== 1'b0) begin n_fail++; $display("FAIL alias_rd_fault: got %b expected 0", f); end
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_latency1();
      test_simultaneous();
      test_drop_busy();
      test_reset_mid_write();
      test_bounds();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
